// File: rtl/floo_wormhole_output_arb.sv
// ----------------------------------------------------------------------------
// floo_wormhole_output_arb
//
// Wormhole arbiter in front of one router output link. NumInputs input ports
// compete for the link. A round-robin pointer picks a winner at packet
// granularity, and the grant stays locked to that input until its tail flit
// (last) completes a handshake. The datapath is purely combinational: valid,
// data, last and ready pass straight through the selected input.
//
// Handshake semantics: a flit transfers on every cycle where valid and ready
// are both high on the same side (valid_i[i] & ready_o[i] upstream,
// valid_o & ready_i downstream). Upstream must hold valid and data stable
// until the transfer. ready_o is only ever high for the granted input.
//
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   valid_i       : per-input flit valid
//   ready_o       : per-input ready (grant_o & ready_i)
//   last_i        : per-input tail marker, qualified by valid_i
//   data_i        : per-input flit payload
//   valid_o       : valid of the selected flit
//   ready_i       : downstream ready
//   data_o        : selected flit, all-zero when nothing is granted
//   last_o        : tail marker of the selected flit
//   grant_o       : one-hot current grant, zero when idle without requests
//   locked_o      : high while a packet holds the lock (FSM state observation)
// ----------------------------------------------------------------------------
module floo_wormhole_output_arb #(
    parameter int unsigned NumInputs = 5,
    parameter type         flit_t    = logic,
    parameter int unsigned IdxWidth  = (NumInputs > 1) ? $clog2(NumInputs) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NumInputs-1:0] valid_i,
    output logic [NumInputs-1:0] ready_o,
    input  logic [NumInputs-1:0] last_i,
    input  flit_t                data_i [NumInputs],
    output logic                 valid_o,
    input  logic                 ready_i,
    output flit_t                data_o,
    output logic                 last_o,
    output logic [NumInputs-1:0] grant_o,
    output logic                 locked_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [IdxWidth-1:0]   rr_q, rr_d;
    logic [IdxWidth-1:0]   lock_idx_q, lock_idx_d;

    logic                  win_found;
    logic [IdxWidth-1:0]   win_idx;
    logic [IdxWidth-1:0]   cand_idx;
    int unsigned           cand;

    logic                  sel_any;
    logic [IdxWidth-1:0]   sel_idx;
    logic                  handshake;

    // Pointer advance with wrap after the last input.
    function automatic logic [IdxWidth-1:0] wrap_inc(input logic [IdxWidth-1:0] idx);
        if (32'(idx) >= NumInputs - 1) begin
            return '0;
        end
        return idx + IdxWidth'(1);
    endfunction

    // Round-robin search starting at rr_q: the first valid input wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < NumInputs; k++) begin
            cand = 32'(rr_q) + k;
            if (cand >= NumInputs) begin
                cand = cand - NumInputs;
            end
            cand_idx = IdxWidth'(cand);
            if (!win_found && valid_i[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Output selection: the locked owner while LOCKED, otherwise the live winner.
    always_comb begin
        sel_any = 1'b0;
        sel_idx = '0;
        if (state_q == LOCKED) begin
            sel_any = 1'b1;
            sel_idx = lock_idx_q;
        end else begin
            sel_any = win_found;
            sel_idx = win_idx;
        end

        grant_o = '0;
        if (sel_any) begin
            grant_o[sel_idx] = 1'b1;
        end

        valid_o   = sel_any & valid_i[sel_idx];
        last_o    = sel_any & last_i[sel_idx];
        data_o    = sel_any ? data_i[sel_idx] : '0;
        ready_o   = grant_o & {NumInputs{ready_i}};
        locked_o  = (state_q == LOCKED);
        handshake = valid_o & ready_i;
    end

    // Next-state logic. rr_q only moves on a completed tail handshake, so
    // fairness is counted in packets rather than flits.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        lock_idx_d = lock_idx_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    if (handshake && last_o) begin
                        // Single-flit packet: done without ever locking.
                        rr_d = wrap_inc(win_idx);
                    end else begin
                        // Stall or head flit: freeze the selection so data_o
                        // stays stable under backpressure.
                        state_d    = LOCKED;
                        lock_idx_d = win_idx;
                    end
                end
            end
            LOCKED: begin
                if (handshake && last_o) begin
                    state_d = IDLE;
                    rr_d    = wrap_inc(lock_idx_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: tb/tb_floo_wormhole_output_arb.sv
// ----------------------------------------------------------------------------
// Bench for floo_wormhole_output_arb with 5 inputs and an 8-bit flit.
// Directed vectors drive the inputs just after each rising edge. Every flit
// expected to leave the arbiter is pushed as {grant, last, data} into exp_q;
// the monitor pops and compares on each falling edge where valid_o & ready_i.
// Immediate checks cover grant/lock/ready/data behaviour between transfers.
// ----------------------------------------------------------------------------
module tb_floo_wormhole_output_arb;

    localparam int N = 5;
    localparam int W = 14;   // {grant[4:0], last, data[7:0]}

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] valid_i;
    logic [N-1:0] ready_o;
    logic [N-1:0] last_i;
    logic [7:0]   data_i [N];
    logic         valid_o;
    logic         ready_i;
    logic [7:0]   data_o;
    logic         last_o;
    logic [N-1:0] grant_o;
    logic         locked_o;

    logic [W-1:0] exp_q[$];
    int           n_vec = 0;
    int           n_err = 0;

    floo_wormhole_output_arb #(
        .NumInputs (N),
        .flit_t    (logic [7:0])
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .last_i   (last_i),
        .data_i   (data_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .data_o   (data_o),
        .last_o   (last_o),
        .grant_o  (grant_o),
        .locked_o (locked_o)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic r);
        valid_i = v;
        last_i  = l;
        ready_i = r;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ev(input int idx, input logic l, input logic [7:0] d);
        logic [N-1:0] g;
        g = '0;
        g[idx] = 1'b1;
        return {g, l, d};
    endfunction

    task automatic push(input int idx, input logic l, input logic [7:0] d);
        exp_q.push_back(ev(idx, l, d));
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && valid_o && ready_i) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_flit: got %h expected none at %0t",
                         {grant_o, last_o, data_o}, $time);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if ({grant_o, last_o, data_o} !== e) begin
                    n_err++;
                    $display("FAIL flit_out: got %h expected %h at %0t",
                             {grant_o, last_o, data_o}, e, $time);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        drive('0, '0, 1'b0);
        for (int i = 0; i < N; i++) data_i[i] = 8'h00;
        repeat (3) step();
        chk("reset_outputs", 16'({grant_o, ready_o, valid_o, last_o, locked_o}), 16'h0);
        chk("reset_data", 16'(data_o), 16'h0);
        rst_n = 1'b1;
        step();
        chk("idle_outputs", 16'({grant_o, ready_o, valid_o, last_o, locked_o, data_o}), 16'h0);

        // ---- single input 2, single-flit packet ----
        step();
        drive(5'b00100, 5'b00100, 1'b1);
        data_i[2] = 8'h21;
        push(2, 1'b1, 8'h21);
        #1;
        chk("single_grant", 16'(grant_o), 16'h04);
        chk("single_ready", 16'(ready_o), 16'h04);
        chk("single_valid_data", 16'({valid_o, data_o}), 16'h121);
        step();
        drive('0, '0, 1'b1);
        #1;
        chk("single_unlocked", 16'(locked_o), 16'h0);

        // ---- round robin: rr starts at 3 after the single packet ----
        for (int c = 0; c < 8; c++) begin
            int idx;
            step();
            drive(5'b11111, 5'b11111, 1'b1);
            for (int i = 0; i < N; i++) data_i[i] = {4'(i), 4'(c)};
            idx = (3 + c) % N;
            push(idx, 1'b1, {4'(idx), 4'(c)});
            #1;
            chk("rr_grant", 16'(grant_o), 16'(1 << idx));
        end
        // rr now points at 1

        // ---- wormhole lock: input 1 three-flit packet, input 0 waiting ----
        step();
        drive(5'b00011, 5'b00001, 1'b1);
        data_i[0] = 8'h01;
        data_i[1] = 8'h11;
        push(1, 1'b0, 8'h11);
        #1;
        chk("worm_head_grant", 16'(grant_o), 16'h02);
        chk("worm_head_unlocked", 16'(locked_o), 16'h0);
        step();
        data_i[1] = 8'h12;
        push(1, 1'b0, 8'h12);
        #1;
        chk("worm_body_lock", 16'({grant_o, locked_o}), 16'({5'b00010, 1'b1}));
        step();
        drive(5'b00011, 5'b00011, 1'b1);
        data_i[1] = 8'h13;
        push(1, 1'b1, 8'h13);
        #1;
        chk("worm_tail_lock", 16'({grant_o, locked_o}), 16'({5'b00010, 1'b1}));
        step();
        drive(5'b00001, 5'b00001, 1'b1);
        push(0, 1'b1, 8'h01);
        #1;
        chk("worm_next_grant", 16'({grant_o, locked_o}), 16'({5'b00001, 1'b0}));
        // rr now points at 1

        // ---- backpressure: input 3 stalled, input 4 joins ----
        step();
        drive(5'b01000, 5'b01000, 1'b0);
        data_i[3] = 8'h31;
        data_i[4] = 8'h41;
        #1;
        chk("bp_grant_c1", 16'({grant_o, ready_o}), 16'({5'b01000, 5'b00000}));
        chk("bp_data_c1", 16'({valid_o, data_o}), 16'h131);
        for (int c = 2; c <= 4; c++) begin
            step();
            drive(5'b11000, 5'b11000, 1'b0);
            #1;
            chk("bp_grant_hold", 16'(grant_o), 16'h08);
            chk("bp_data_hold", 16'(data_o), 16'h31);
        end
        step();
        drive(5'b11000, 5'b11000, 1'b1);
        push(3, 1'b1, 8'h31);
        #1;
        chk("bp_release_ready", 16'(ready_o), 16'h08);
        step();
        drive(5'b10000, 5'b10000, 1'b1);
        push(4, 1'b1, 8'h41);
        #1;
        chk("bp_next_grant", 16'(grant_o), 16'h10);
        // rr now points at 0

        // ---- mid-packet bubble on input 2 ----
        step();
        drive(5'b00100, 5'b00000, 1'b1);
        data_i[0] = 8'h01;
        data_i[1] = 8'h11;
        data_i[2] = 8'h21;
        push(2, 1'b0, 8'h21);
        for (int c = 0; c < 2; c++) begin
            step();
            drive(5'b00011, 5'b00011, 1'b1);
            #1;
            chk("bubble_grant", 16'({grant_o, ready_o, valid_o}), 16'({5'b00100, 5'b00100, 1'b0}));
        end
        step();
        drive(5'b00111, 5'b00111, 1'b1);
        data_i[2] = 8'h22;
        push(2, 1'b1, 8'h22);
        #1;
        chk("bubble_tail_grant", 16'(grant_o), 16'h04);
        step();
        drive(5'b00011, 5'b00011, 1'b1);
        push(0, 1'b1, 8'h01);
        step();
        drive(5'b00010, 5'b00010, 1'b1);
        push(1, 1'b1, 8'h11);
        #1;
        chk("bubble_after_grant", 16'(grant_o), 16'h02);
        // rr now points at 2

        // ---- asynchronous reset while locked ----
        step();
        drive(5'b01000, 5'b00000, 1'b1);
        data_i[3] = 8'h31;
        push(3, 1'b0, 8'h31);
        step();
        drive(5'b01010, 5'b01010, 1'b0);
        data_i[1] = 8'h11;
        data_i[3] = 8'h32;
        #1;
        chk("areset_pre_lock", 16'({grant_o, locked_o}), 16'({5'b01000, 1'b1}));
        rst_n = 1'b0;
        #1;
        chk("areset_unlock", 16'(locked_o), 16'h0);
        chk("areset_grant_rr0", 16'(grant_o), 16'h02);
        #1;
        rst_n = 1'b1;
        step();
        drive(5'b01010, 5'b01010, 1'b1);
        push(1, 1'b1, 8'h11);
        #1;
        chk("areset_restart_grant", 16'(grant_o), 16'h02);
        step();
        drive(5'b01000, 5'b01000, 1'b1);
        push(3, 1'b1, 8'h32);
        step();
        drive('0, '0, 1'b0);

        // ---- drain check ----
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) step();
        chk("scoreboard_drained", 16'(exp_q.size()), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
